// File: rtl/alu_if_pkg.sv
// Shared types and constants for the UART <-> ALU frame sequencer.
package alu_if_pkg;

    // Default data and opcode widths
    localparam int unsigned DEF_N   = 8;
    localparam int unsigned DEF_OPW = 6;

    // Frame sequencer states
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_CALC = 3'd3,
        S_SEND = 3'd4
    } state_t;

    // ALU opcode encoding
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/alu_uart_interface_frame_timer.sv
// Mid-frame idle counter; flags expiry on the cycle it holds TIMEOUT-1.
module frame_timer #(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    // Expiry only counts while enabled, so an arriving byte always wins
    assign expired = en && (r_cnt == LAST);

    // Idle counter: clear has priority, wraps to zero on expiry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (expired) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_uart_interface.sv
// Frame sequencer: collects A, B, opcode bytes from the UART, presents them
// to the ALU, waits one settle cycle and sends the result byte back.
module alu_uart_interface
    import alu_if_pkg::*;
#(
    parameter int unsigned N       = DEF_N,
    parameter int unsigned OPW     = DEF_OPW,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   rx_data,
    input  logic           rx_done,
    input  logic [N-1:0]   alu_result,
    input  logic           tx_busy,
    output logic [N-1:0]   bus_a,
    output logic [N-1:0]   bus_b,
    output logic [OPW-1:0] op_code,
    output logic [N-1:0]   tx_data,
    output logic           tx_start,
    output logic           rx_overrun
);

    state_t         r_state,    w_state_nxt;
    logic [N-1:0]   r_bus_a,    w_bus_a_nxt;
    logic [N-1:0]   r_bus_b,    w_bus_b_nxt;
    logic [OPW-1:0] r_op_code,  w_op_code_nxt;
    logic [N-1:0]   r_tx_data,  w_tx_data_nxt;
    logic           r_tx_start, w_tx_start_nxt;
    logic           r_overrun,  w_overrun_nxt;

    logic w_in_frame;
    logic w_timer_en;
    logic w_timer_clr;
    logic w_expired;

    // Timer runs only while waiting mid-frame with no byte arriving
    always_comb begin
        w_in_frame  = (r_state == S_B) || (r_state == S_OP);
        w_timer_en  = w_in_frame && !rx_done;
        w_timer_clr = !w_timer_en;
    end

    frame_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_frame_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (w_timer_clr),
        .en     (w_timer_en),
        .expired(w_expired)
    );

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_bus_a_nxt    = r_bus_a;
        w_bus_b_nxt    = r_bus_b;
        w_op_code_nxt  = r_op_code;
        w_tx_data_nxt  = r_tx_data;
        w_tx_start_nxt = 1'b0;
        w_overrun_nxt  = r_overrun;

        case (r_state)
            S_A: begin
                if (rx_done) begin
                    w_bus_a_nxt = rx_data;
                    w_state_nxt = S_B;
                end
            end
            S_B: begin
                if (rx_done) begin
                    w_bus_b_nxt = rx_data;
                    w_state_nxt = S_OP;
                end else if (w_expired) begin
                    w_state_nxt = S_A;
                end
            end
            S_OP: begin
                if (rx_done) begin
                    w_op_code_nxt = rx_data[OPW-1:0];
                    w_state_nxt   = S_CALC;
                end else if (w_expired) begin
                    w_state_nxt = S_A;
                end
            end
            S_CALC: begin
                if (rx_done) begin
                    w_overrun_nxt = 1'b1;
                end
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (rx_done) begin
                    w_overrun_nxt = 1'b1;
                end
                if (!tx_busy) begin
                    w_tx_data_nxt  = alu_result;
                    w_tx_start_nxt = 1'b1;
                    w_state_nxt    = S_A;
                end
            end
            default: begin
                w_state_nxt = S_A;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_A;
            r_bus_a    <= '0;
            r_bus_b    <= '0;
            r_op_code  <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bus_a    <= w_bus_a_nxt;
            r_bus_b    <= w_bus_b_nxt;
            r_op_code  <= w_op_code_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_overrun  <= w_overrun_nxt;
        end
    end

    assign bus_a      = r_bus_a;
    assign bus_b      = r_bus_b;
    assign op_code    = r_op_code;
    assign tx_data    = r_tx_data;
    assign tx_start   = r_tx_start;
    assign rx_overrun = r_overrun;

endmodule
